// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command controller: frame layout,
// command codes, controller states and the status register address.
package spi_cmd_pkg;

  localparam int CMD_W  = 4;
  localparam int ADDR_W = 4;
  localparam int REG_W  = 16;

  // Frame field positions: [23:20] cmd, [19:16] addr, [15:0] data
  localparam int CMD_MSB  = 23;
  localparam int CMD_LSB  = 20;
  localparam int ADDR_MSB = 19;
  localparam int ADDR_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;

  // Address that maps to the sticky status flags instead of a shadow register
  localparam logic [ADDR_W-1:0] STATUS_ADDR = 4'hF;
  // Command field returned in the response to an unknown opcode
  localparam logic [CMD_W-1:0]  BAD_CMD_TAG = 4'hF;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP   = 4'h0,
    CMD_WRITE = 4'h1,
    CMD_READ  = 4'h2,
    CMD_ARM   = 4'h3,
    CMD_TRIG  = 4'h4
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_LOAD,
    ST_COMMIT
  } state_e;

  // Status word layout seen by a READ of STATUS_ADDR
  function automatic logic [REG_W-1:0] status_word(input logic overrun,
                                                   input logic bad_cmd);
    return {14'b0, overrun, bad_cmd};
  endfunction

endpackage

// File: rtl/cmd_regbank.sv
// Shadow register bank: one write port (host WRITE) and two read ports,
// one for host READ responses and one for streaming to the delay core.
// Reads outside 0..NREG-1 return zero.
module cmd_regbank
  import spi_cmd_pkg::*;
#(
  parameter int NREG = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [REG_W-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [REG_W-1:0]  rdata_a_o,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [REG_W-1:0]  rdata_b_o
);

  logic [REG_W-1:0] shadow_q [NREG];

  // Shadow array storage, cleared on reset, written only for in-range addresses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (we_i && (int'(waddr_i) < NREG)) begin
      shadow_q[waddr_i] <= wdata_i;
    end
  end

  // Two independent asynchronous read ports
  always_comb begin
    rdata_a_o = '0;
    rdata_b_o = '0;
    if (int'(raddr_a_i) < NREG) rdata_a_o = shadow_q[raddr_a_i];
    if (int'(raddr_b_i) < NREG) rdata_b_o = shadow_q[raddr_b_i];
  end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command controller: decodes 24-bit host frames into shadow register
// writes/reads, a software trigger, and an ARM sequence that streams every
// shadow register to the delay core over a valid/ready link and then
// pulses arm. Frames arriving while busy are dropped and flagged.
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int NREG       = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_done,
  input  logic [DATA_WIDTH-1:0] spi_dout,
  output logic [DATA_WIDTH-1:0] spi_din,
  output logic                  cfg_valid,
  input  logic                  cfg_ready,
  output logic [ADDR_W-1:0]     cfg_addr,
  output logic [REG_W-1:0]      cfg_data,
  output logic                  arm,
  output logic                  soft_trig,
  output logic                  busy
);

  localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(NREG - 1);

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   frame_q;
  logic [ADDR_W-1:0]       index_q;
  logic [DATA_WIDTH-1:0]   spi_din_q;
  logic                    cfg_valid_q;
  logic                    arm_q;
  logic                    soft_trig_q;
  logic                    bad_cmd_q;
  logic                    overrun_q;

  logic                    bad_cmd_d;
  logic                    overrun_d;
  logic [DATA_WIDTH-1:0]   resp_d;

  logic [CMD_W-1:0]        f_cmd;
  logic [ADDR_W-1:0]       f_addr;
  logic [REG_W-1:0]        f_data;
  logic                    decoding;
  logic                    cmd_valid;
  logic                    addr_is_status;
  logic                    addr_in_bank;
  logic                    shadow_we;
  logic [REG_W-1:0]        bank_rdata;
  logic [REG_W-1:0]        load_rdata;
  logic [REG_W-1:0]        read_rdata;

  assign f_cmd          = frame_q[CMD_MSB:CMD_LSB];
  assign f_addr         = frame_q[ADDR_MSB:ADDR_LSB];
  assign f_data         = frame_q[DATA_MSB:DATA_LSB];
  assign decoding       = (state_q == ST_DECODE);
  assign cmd_valid      = f_cmd inside {CMD_NOP, CMD_WRITE, CMD_READ, CMD_ARM, CMD_TRIG};
  assign addr_is_status = (f_addr == STATUS_ADDR);
  assign addr_in_bank   = !addr_is_status && (int'(f_addr) < NREG);
  assign shadow_we      = decoding && (f_cmd == CMD_WRITE) && addr_in_bank;
  assign read_rdata     = addr_is_status ? status_word(overrun_q, bad_cmd_q) : bank_rdata;

  cmd_regbank #(
    .NREG(NREG)
  ) u_regbank (
    .clk       (clk),
    .rst       (rst),
    .we_i      (shadow_we),
    .waddr_i   (f_addr),
    .wdata_i   (f_data),
    .raddr_a_i (f_addr),
    .rdata_a_o (bank_rdata),
    .raddr_b_i (index_q),
    .rdata_b_o (load_rdata)
  );

  // Sticky flag next-state and response word; a set in the same cycle as a clear wins
  always_comb begin
    logic flag_clr;
    logic bad_set;
    logic ovr_set;
    flag_clr = decoding && (f_cmd == CMD_WRITE) && addr_is_status;
    bad_set  = decoding && (!cmd_valid ||
               (((f_cmd == CMD_WRITE) || (f_cmd == CMD_READ)) &&
                !addr_is_status && !addr_in_bank));
    ovr_set  = spi_done && (state_q != ST_IDLE);
    bad_cmd_d = bad_set | (bad_cmd_q & ~flag_clr);
    overrun_d = ovr_set | (overrun_q & ~flag_clr);

    if (!cmd_valid) begin
      resp_d = {BAD_CMD_TAG, f_addr, 16'h0000};
    end else if (f_cmd == CMD_READ) begin
      resp_d = {f_cmd, f_addr, read_rdata};
    end else begin
      resp_d = {f_cmd, f_addr, 16'h0000};
    end
  end

  // Control FSM: frame capture, command dispatch, config streaming, commit pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      frame_q     <= '0;
      index_q     <= '0;
      spi_din_q   <= '0;
      cfg_valid_q <= 1'b0;
      arm_q       <= 1'b0;
      soft_trig_q <= 1'b0;
      bad_cmd_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      arm_q       <= 1'b0;
      soft_trig_q <= 1'b0;
      bad_cmd_q   <= bad_cmd_d;
      overrun_q   <= overrun_d;
      case (state_q)
        ST_IDLE: begin
          if (spi_done) begin
            frame_q <= spi_dout;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          spi_din_q <= resp_d;
          state_q   <= ST_IDLE;
          if (f_cmd == CMD_ARM) begin
            state_q     <= ST_LOAD;
            index_q     <= '0;
            cfg_valid_q <= 1'b1;
          end
          if (f_cmd == CMD_TRIG) soft_trig_q <= 1'b1;
        end
        ST_LOAD: begin
          if (cfg_valid_q && cfg_ready) begin
            if (index_q == LAST_INDEX) begin
              cfg_valid_q <= 1'b0;
              index_q     <= '0;
              state_q     <= ST_COMMIT;
            end else begin
              index_q <= index_q + 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          arm_q   <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign spi_din   = spi_din_q;
  assign cfg_valid = cfg_valid_q;
  assign cfg_addr  = index_q;
  assign cfg_data  = load_rdata;
  assign arm       = arm_q;
  assign soft_trig = soft_trig_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: directed scenarios plus randomized frames checked
// against a behavioural model of the register/flag/response rules.
module tb_spi_cmd_ctrl;

  localparam int NREG = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        spi_done = 1'b0;
  logic [23:0] spi_dout = '0;
  logic [23:0] spi_din;
  logic        cfg_valid;
  logic        cfg_ready = 1'b0;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        arm;
  logic        soft_trig;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  logic [15:0] m_shadow [16];
  logic        m_bad;
  logic        m_ovr;

  // observations from the last frame
  logic [19:0] xfer_q [$];
  int          o_trig, o_arm, o_trig_cyc, o_arm_cyc;
  int          o_unstable, o_stall_cycles, o_timeout;
  logic [23:0] o_din;

  always #5 clk = ~clk;

  spi_cmd_ctrl #(.DATA_WIDTH(24), .NREG(NREG)) dut (
    .clk(clk), .rst(rst), .spi_done(spi_done), .spi_dout(spi_dout),
    .spi_din(spi_din), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .arm(arm),
    .soft_trig(soft_trig), .busy(busy)
  );

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_shadow[i] = 16'h0000;
    m_bad = 1'b0;
    m_ovr = 1'b0;
  endtask

  // Apply one accepted frame to the model; returns the expected response
  task automatic model_frame(input logic [23:0] w, output logic [23:0] din,
                             output int trig, output int armc);
    logic [3:0]  c, a;
    logic [15:0] d;
    c = w[23:20]; a = w[19:16]; d = w[15:0];
    trig = 0; armc = 0;
    if (c > 4'h4) begin
      din = {4'hF, a, 16'h0000};
      m_bad = 1'b1;
    end else begin
      din = {c, a, 16'h0000};
      if (c == 4'h1) begin
        if (a == 4'hF) begin m_bad = 1'b0; m_ovr = 1'b0; end
        else if (int'(a) < NREG) m_shadow[a] = d;
        else m_bad = 1'b1;
      end
      if (c == 4'h2) begin
        if (a == 4'hF) din[15:0] = {14'd0, m_ovr, m_bad};
        else if (int'(a) < NREG) din[15:0] = m_shadow[a];
        else m_bad = 1'b1;
      end
      trig = (c == 4'h4) ? 1 : 0;
      armc = (c == 4'h3) ? 1 : 0;
    end
  endtask

  // Drive one frame and observe until the controller is idle again.
  // rmode: 0 ready always high, 1 stall 3 cycles at index 5, 2 random.
  task automatic run_frame(input logic [23:0] w, input int rmode, input int inject_cyc);
    int cyc, stall_left;
    logic prev_stall, stalled_once;
    logic [3:0] pa;
    logic [15:0] pd;
    xfer_q.delete();
    o_trig = 0; o_arm = 0; o_trig_cyc = -1; o_arm_cyc = -1;
    o_unstable = 0; o_stall_cycles = 0; o_timeout = 0;
    stall_left = 0; prev_stall = 1'b0; stalled_once = 1'b0; pa = '0; pd = '0;
    spi_dout = w; spi_done = 1'b1;
    for (cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk); #1;
      spi_done = 1'b0;
      if (cyc == inject_cyc) begin spi_dout = 24'h10BEEF; spi_done = 1'b1; end
      if (soft_trig) begin o_trig++; o_trig_cyc = cyc; end
      if (arm) begin o_arm++; o_arm_cyc = cyc; end
      if (cfg_valid) begin
        if (prev_stall && (cfg_addr !== pa || cfg_data !== pd)) o_unstable++;
        if (rmode == 0) cfg_ready = 1'b1;
        else if (rmode == 1) begin
          if (cfg_addr == 4'd5 && !stalled_once) begin stall_left = 3; stalled_once = 1'b1; end
          cfg_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end else cfg_ready = ($urandom_range(0, 2) != 0);
        if (cfg_ready) xfer_q.push_back({cfg_addr, cfg_data});
        else o_stall_cycles++;
        prev_stall = !cfg_ready; pa = cfg_addr; pd = cfg_data;
      end else begin
        cfg_ready = 1'($urandom_range(0, 1));
        prev_stall = 1'b0;
      end
      if (cyc >= 2 && !busy && !spi_done) break;
    end
    if (cyc > 200) o_timeout = 1;
    cfg_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (soft_trig) o_trig++;
      if (arm) o_arm++;
    end
    o_din = spi_din;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    spi_dout = 24'h131234; spi_done = 1'b1;
    repeat (3) @(posedge clk);
    #1 spi_done = 1'b0;
    n_checks++; if (spi_din !== 24'h0) begin n_fail++; $display("FAIL rst_spi_din got %h want 000000", spi_din); end
    n_checks++; if (cfg_valid !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_valid got %b want 0", cfg_valid); end
    n_checks++; if (arm !== 1'b0) begin n_fail++; $display("FAIL rst_arm got %b want 0", arm); end
    n_checks++; if (soft_trig !== 1'b0) begin n_fail++; $display("FAIL rst_soft_trig got %b want 0", soft_trig); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_checks++; if (cfg_addr !== 4'h0) begin n_fail++; $display("FAIL rst_cfg_addr got %h want 0", cfg_addr); end
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy_after got %b want 0", busy); end
  endtask

  task automatic test_write_read();
    logic [23:0] e; int t, a;
    model_frame(24'h131234, e, t, a);
    run_frame(24'h131234, 0, 0);
    n_checks++; if (o_din !== 24'h130000) begin n_fail++; $display("FAIL write_resp got %h want 130000", o_din); end
    model_frame(24'h230000, e, t, a);
    run_frame(24'h230000, 0, 0);
    n_checks++; if (o_din !== 24'h231234) begin n_fail++; $display("FAIL read_resp got %h want 231234", o_din); end
  endtask

  task automatic test_bad_cmd();
    logic [23:0] e; int t, a;
    model_frame(24'h700000, e, t, a);
    run_frame(24'h700000, 0, 0);
    n_checks++; if (o_din !== 24'hF00000) begin n_fail++; $display("FAIL bad_resp got %h want F00000", o_din); end
    n_checks++; if (o_trig !== 0 || o_arm !== 0) begin n_fail++; $display("FAIL bad_side_effect got trig=%0d arm=%0d want 0/0", o_trig, o_arm); end
    model_frame(24'h2F0000, e, t, a);
    run_frame(24'h2F0000, 0, 0);
    n_checks++; if (o_din !== 24'h2F0001) begin n_fail++; $display("FAIL status_bad got %h want 2F0001", o_din); end
    model_frame(24'h1F0000, e, t, a);
    run_frame(24'h1F0000, 0, 0);
    model_frame(24'h2F0000, e, t, a);
    run_frame(24'h2F0000, 0, 0);
    n_checks++; if (o_din !== 24'h2F0000) begin n_fail++; $display("FAIL status_clr got %h want 2F0000", o_din); end
  endtask

  task automatic test_trig();
    logic [23:0] e; int t, a;
    model_frame(24'h400000, e, t, a);
    run_frame(24'h400000, 0, 0);
    n_checks++; if (o_trig !== 1) begin n_fail++; $display("FAIL trig_count got %0d want 1", o_trig); end
    n_checks++; if (o_trig_cyc !== 2) begin n_fail++; $display("FAIL trig_latency got %0d want 2", o_trig_cyc); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL trig_busy got %b want 0", busy); end
    n_checks++; if (o_din !== 24'h400000) begin n_fail++; $display("FAIL trig_resp got %h want 400000", o_din); end
  endtask

  task automatic test_arm_stall();
    logic [23:0] w, e; int t, a;
    for (int i = 0; i < NREG; i++) begin
      w = {4'h1, 4'(i), 16'($urandom)};
      model_frame(w, e, t, a);
      run_frame(w, 0, 0);
    end
    model_frame(24'h300000, e, t, a);
    run_frame(24'h300000, 1, 0);
    n_checks++; if (xfer_q.size() !== NREG) begin n_fail++; $display("FAIL stall_xfer_count got %0d want %0d", xfer_q.size(), NREG); end
    for (int i = 0; i < xfer_q.size() && i < NREG; i++) begin
      n_checks++;
      if (xfer_q[i] !== {4'(i), m_shadow[i]}) begin n_fail++; $display("FAIL stall_xfer%0d got %h want %h", i, xfer_q[i], {4'(i), m_shadow[i]}); end
    end
    n_checks++; if (o_unstable !== 0) begin n_fail++; $display("FAIL stall_stable got %0d changes want 0", o_unstable); end
    n_checks++; if (o_stall_cycles !== 3) begin n_fail++; $display("FAIL stall_cycles got %0d want 3", o_stall_cycles); end
    n_checks++; if (o_arm !== 1) begin n_fail++; $display("FAIL stall_arm_count got %0d want 1", o_arm); end
    n_checks++; if (o_arm_cyc !== NREG + 6) begin n_fail++; $display("FAIL stall_arm_cyc got %0d want %0d", o_arm_cyc, NREG + 6); end
    n_checks++; if (o_din !== e) begin n_fail++; $display("FAIL arm_resp got %h want %h", o_din, e); end
  endtask

  task automatic test_overrun();
    logic [23:0] e; int t, a;
    model_frame(24'h300000, e, t, a);
    m_ovr = 1'b1;
    run_frame(24'h300000, 0, 5);
    n_checks++; if (o_arm_cyc !== NREG + 3) begin n_fail++; $display("FAIL ovr_arm_latency got %0d want %0d", o_arm_cyc, NREG + 3); end
    n_checks++; if (o_arm !== 1) begin n_fail++; $display("FAIL ovr_arm_count got %0d want 1", o_arm); end
    n_checks++; if (xfer_q.size() !== NREG) begin n_fail++; $display("FAIL ovr_xfer_count got %0d want %0d", xfer_q.size(), NREG); end
    for (int i = 0; i < xfer_q.size() && i < NREG; i++) begin
      n_checks++;
      if (xfer_q[i] !== {4'(i), m_shadow[i]}) begin n_fail++; $display("FAIL ovr_xfer%0d got %h want %h", i, xfer_q[i], {4'(i), m_shadow[i]}); end
    end
    n_checks++; if (o_din !== 24'h300000) begin n_fail++; $display("FAIL ovr_din got %h want 300000", o_din); end
    model_frame(24'h2F0000, e, t, a);
    run_frame(24'h2F0000, 0, 0);
    n_checks++; if (o_din !== 24'h2F0002) begin n_fail++; $display("FAIL ovr_status got %h want 2F0002", o_din); end
    model_frame(24'h200000, e, t, a);
    run_frame(24'h200000, 0, 0);
    n_checks++; if (o_din !== e) begin n_fail++; $display("FAIL ovr_reg0 got %h want %h", o_din, e); end
    model_frame(24'h1F0000, e, t, a);
    run_frame(24'h1F0000, 0, 0);
  endtask

  task automatic test_random();
    logic [23:0] w, e; int t, a;
    for (int n = 0; n < 60; n++) begin
      w = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 16'($urandom)};
      model_frame(w, e, t, a);
      run_frame(w, 2, 0);
      n_checks++; if (o_timeout !== 0) begin n_fail++; $display("FAIL rnd%0d_timeout frame %h", n, w); end
      n_checks++; if (o_din !== e) begin n_fail++; $display("FAIL rnd%0d_din frame %h got %h want %h", n, w, o_din, e); end
      n_checks++; if (o_trig !== t) begin n_fail++; $display("FAIL rnd%0d_trig got %0d want %0d", n, o_trig, t); end
      n_checks++; if (o_arm !== a) begin n_fail++; $display("FAIL rnd%0d_arm got %0d want %0d", n, o_arm, a); end
      n_checks++; if (xfer_q.size() !== a * NREG) begin n_fail++; $display("FAIL rnd%0d_xfers got %0d want %0d", n, xfer_q.size(), a * NREG); end
      for (int i = 0; i < xfer_q.size() && i < NREG; i++) begin
        n_checks++;
        if (xfer_q[i] !== {4'(i), m_shadow[i]}) begin n_fail++; $display("FAIL rnd%0d_xfer%0d got %h want %h", n, i, xfer_q[i], {4'(i), m_shadow[i]}); end
      end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [23:0] w, e; int t, a, waited, arms;
    for (int i = 0; i < NREG; i++) begin
      w = {4'h1, 4'(i), 16'h1000 + 16'(i)};
      model_frame(w, e, t, a);
      run_frame(w, 0, 0);
    end
    spi_dout = 24'h300000; spi_done = 1'b1; cfg_ready = 1'b1;
    waited = 0; arms = 0;
    @(posedge clk); #1 spi_done = 1'b0;
    while (!(cfg_valid === 1'b1 && cfg_addr === 4'd7) && waited < 100) begin
      @(posedge clk); #1;
      waited++;
      if (arm) arms++;
    end
    n_checks++; if (waited >= 100) begin n_fail++; $display("FAIL midrst_reach_idx7 waited %0d cycles want <100", waited); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (cfg_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_async_valid got %b want 0", cfg_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
    repeat (3) begin @(posedge clk); #1; if (arm) arms++; end
    rst = 1'b1;
    cfg_ready = 1'b0;
    model_reset();
    repeat (20) begin @(posedge clk); #1; if (arm) arms++; end
    n_checks++; if (arms !== 0) begin n_fail++; $display("FAIL midrst_arm got %0d pulses want 0", arms); end
    model_frame(24'h300000, e, t, a);
    run_frame(24'h300000, 0, 0);
    n_checks++; if (xfer_q.size() !== NREG) begin n_fail++; $display("FAIL midrst_xfer_count got %0d want %0d", xfer_q.size(), NREG); end
    for (int i = 0; i < xfer_q.size() && i < NREG; i++) begin
      n_checks++;
      if (xfer_q[i] !== {4'(i), 16'h0000}) begin n_fail++; $display("FAIL midrst_xfer%0d got %h want %h", i, xfer_q[i], {4'(i), 16'h0000}); end
    end
    n_checks++; if (o_arm !== 1) begin n_fail++; $display("FAIL midrst_rearm got %0d want 1", o_arm); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_bad_cmd();
    test_trig();
    test_arm_stall();
    test_overrun();
    test_random();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ctrl.md
SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, default 24, SPI frame width; SHALL be fixed at 24 for this frame format.
REQ-002 Parameter: NREG, default 15, number of writable shadow registers (addresses 0..NREG-1).
REQ-003 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 spi_done  input  1  one-cycle pulse from the SPI slave: frame received.
REQ-006 spi_dout  input  24  received frame, valid while spi_done is high.
REQ-007 spi_din  output  24  response word sampled by the SPI slave for the next frame.
REQ-008 cfg_valid  output  1  configuration transfer valid to the delay core.
REQ-009 cfg_ready  input  1  delay core accepts transfer when high with cfg_valid.
REQ-010 cfg_addr  output  4  register index of current transfer.
REQ-011 cfg_data  output  16  register value of current transfer.
REQ-012 arm  output  1  one-cycle pulse: new configuration committed.
REQ-013 soft_trig  output  1  one-cycle software trigger pulse.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 Frame format: [23:20] cmd, [19:16] addr, [15:0] data.
REQ-016 Commands: 0x0 NOP, 0x1 WRITE, 0x2 READ, 0x3 ARM, 0x4 TRIG; any other code SHALL set sticky bad_cmd and do nothing else.
REQ-017 FSM states: IDLE, DECODE, LOAD, COMMIT; spi_dout SHALL be captured on spi_done in IDLE, transitioning to DECODE.
REQ-018 WRITE, addr < NREG: shadow[addr] <= data in DECODE; addr = 0xF: clear sticky flags; other addr: set bad_cmd; return to IDLE.
REQ-019 READ: addr < NREG returns shadow[addr]; addr 0xF returns {14'b0, overrun, bad_cmd}; other addr returns 16'h0000 and sets bad_cmd.
REQ-020 spi_din SHALL update exactly one cycle after DECODE to {cmd, addr, rdata} for READ, {cmd, addr, 16'h0000} for other valid commands, {4'hF, addr, 16'h0000} for bad commands.
REQ-021 Readback of frame N SHALL be carried by frame N+1; the host SHALL deassert ss at least 4 clk cycles between frames.
REQ-022 TRIG: soft_trig SHALL pulse one cycle, in the cycle after DECODE; FSM SHALL return to IDLE.
REQ-023 ARM: DECODE -> LOAD with index 0; in LOAD, cfg_valid=1, cfg_addr=index, cfg_data=shadow[index].
REQ-024 A transfer completes in a cycle with cfg_valid & cfg_ready; index then increments; after index NREG-1 completes, FSM SHALL go to COMMIT.
REQ-025 cfg_valid, cfg_addr and cfg_data SHALL remain stable until accepted; cfg_valid SHALL be low outside LOAD.
REQ-026 COMMIT: arm SHALL pulse for exactly one cycle, then FSM returns to IDLE; ARM latency with cfg_ready held high SHALL be NREG+3 cycles from spi_done to arm.
REQ-027 spi_done while busy: frame SHALL be dropped, sticky overrun set, shadow registers and spi_din unchanged.
REQ-028 Shadow writes SHALL NOT occur during LOAD, because frames are dropped there, so transferred values are coherent.
REQ-029 Sticky flags SHALL clear only on WRITE to addr 0xF or on reset; a simultaneous set and clear SHALL resolve to set.

Reset
REQ-030 On rst low: FSM IDLE, index 0, all shadow registers 16'h0000, flags 0, spi_din 24'h000000, cfg_valid/arm/soft_trig/busy 0.
REQ-031 Reset asserted mid-LOAD SHALL abort the sequence immediately, with no arm pulse; the core keeps partial values until the next ARM.

Structure
REQ-032 Shared package spi_cmd_pkg: command codes, state enum, STATUS_ADDR = 4'hF, frame field positions.
REQ-033 One sub-module, cmd_regbank: shadow register array with one write port and two read ports (READ and LOAD).

Verification
REQ-034 WRITE 0x1_3_1234, then READ 0x2_3_0000 -> response frame equals 24'h231234.
REQ-035 Opcode 0x7, then READ 0x2_F_0000 -> first response 24'hF00000, status read returns data 16'h0001.
REQ-036 ARM with cfg_ready stalled 3 cycles on index 5 -> 15 transfers in order 0..14, index 5 held stable, one arm pulse after index 14.
REQ-037 spi_done during LOAD -> frame ignored, overrun set (status 16'h0002), ARM sequence unaffected.
REQ-038 rst asserted at LOAD index 7 -> cfg_valid low asynchronously, no arm pulse, shadow registers all zero.
REQ-039 TRIG 0x4_0_0000 -> single soft_trig pulse 2 cycles after spi_done, busy low afterwards.
